// File: rtl/bcd_digit_serial_ctrl_if.sv
// Operand/result handshake and shared BCD digit-slice wiring for bcd_digit_serial_ctrl.
// The slave modport is the controller; the master side owns the operands, consumer and slice.
interface bcd_digit_serial_ctrl_if #(
  parameter int unsigned NDIG = 4
);
  localparam int unsigned W = 4 * NDIG;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_bcd;
  logic [W-1:0] b_bcd;
  logic         dp_issue;
  logic [3:0]   dp_a;
  logic [3:0]   dp_b;
  logic         dp_cin;
  logic [3:0]   dp_sum;
  logic         dp_tens;
  logic [1:0]   zone_phase;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_bcd;
  logic         cout;
  logic         err;

  modport master (
    output in_valid, a_bcd, b_bcd, dp_sum, dp_tens, out_ready,
    input  in_ready, dp_issue, dp_a, dp_b, dp_cin, zone_phase, out_valid, sum_bcd, cout, err
  );

  modport slave (
    input  in_valid, a_bcd, b_bcd, dp_sum, dp_tens, out_ready,
    output in_ready, dp_issue, dp_a, dp_b, dp_cin, zone_phase, out_valid, sum_bcd, cout, err
  );
endinterface

// File: rtl/bcd_digit_serial_ctrl.sv
// Digit-serial BCD adder sequencer: shares one NML BCD digit slice across NDIG digits,
// rippling the Tens carry LSD first and driving the slice clock-zone status.
module bcd_digit_serial_ctrl #(
  parameter int unsigned NDIG    = 4,
  parameter int unsigned ADD_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_digit_serial_ctrl_if.slave bus
);
  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CW = (ADD_LAT < 2) ? 2 : $clog2(ADD_LAT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  localparam logic [1:0] ZONE_RELAX   = 2'b00;
  localparam logic [1:0] ZONE_SWITCH  = 2'b01;
  localparam logic [1:0] ZONE_HOLD    = 2'b10;
  localparam logic [1:0] ZONE_RELEASE = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [CW-1:0] cnt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          dp_issue_q;
  logic [3:0]    dp_a_q;
  logic [3:0]    dp_b_q;
  logic          dp_cin_q;
  logic [1:0]    zone_q;
  logic          cout_q;
  logic          err_q;
  logic          bad_c;

  assign idx_nxt = idx + IW'(1);

  // Any non-decimal digit in either incoming operand
  always_comb begin
    bad_c = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bus.a_bcd[4*i +: 4] > 4'd9 || bus.b_bcd[4*i +: 4] > 4'd9) bad_c = 1'b1;
    end
  end

  // dp_cin doubles as the rippled Tens carry between digit passes
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx         <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dp_issue_q  <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_cin_q    <= 1'b0;
      zone_q      <= ZONE_RELAX;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dp_issue_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a_bcd;
            b_q        <= bus.b_bcd;
            sum_q      <= '0;
            idx        <= '0;
            cout_q     <= 1'b0;
            in_ready_q <= 1'b0;
            if (bad_c) begin
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              err_q      <= 1'b0;
              dp_issue_q <= 1'b1;
              dp_a_q     <= bus.a_bcd[3:0];
              dp_b_q     <= bus.b_bcd[3:0];
              dp_cin_q   <= 1'b0;
              zone_q     <= ZONE_SWITCH;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt    <= CW'(ADD_LAT);
          zone_q <= (ADD_LAT == 1) ? ZONE_RELEASE : ZONE_HOLD;
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            sum_q[{idx, 2'b00} +: 4] <= bus.dp_sum;
            if (idx == LAST_IDX) begin
              cout_q      <= bus.dp_tens;
              out_valid_q <= 1'b1;
              zone_q      <= ZONE_RELAX;
              state       <= DONE;
            end else begin
              idx        <= idx_nxt;
              dp_issue_q <= 1'b1;
              dp_a_q     <= a_q[{idx_nxt, 2'b00} +: 4];
              dp_b_q     <= b_q[{idx_nxt, 2'b00} +: 4];
              dp_cin_q   <= bus.dp_tens;
              zone_q     <= ZONE_SWITCH;
              state      <= ISSUE;
            end
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(2)) zone_q <= ZONE_RELEASE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.dp_issue   = dp_issue_q;
  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.dp_cin     = dp_cin_q;
  assign bus.zone_phase = zone_q;
  assign bus.sum_bcd    = sum_q;
  assign bus.cout       = cout_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_bcd_digit_serial_ctrl.sv
// Bench for bcd_digit_serial_ctrl: two instances (ADD_LAT=4 and ADD_LAT=1) with a latency-accurate
// slice model, a decimal-arithmetic reference checked every cycle, and directed literal checks.
module tb_bcd_digit_serial_ctrl;
  localparam int NDIG = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        in_valid_v  [2];
  logic        out_ready_v [2];
  logic [15:0] a_v         [2];
  logic [15:0] b_v         [2];
  logic        in_ready_v  [2];
  logic        out_valid_v [2];
  logic        dp_issue_v  [2];
  logic [3:0]  dp_a_v      [2];
  logic [3:0]  dp_b_v      [2];
  logic        dp_cin_v    [2];
  logic [1:0]  zone_v      [2];
  logic [15:0] sum_v       [2];
  logic        cout_v      [2];
  logic        err_v       [2];

  task automatic chk(input string name, input int g, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[inst%0d] cyc=%0d: got %0h, expected %0h", name, g, cyc, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    int t = n;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [15:0] v);
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 4 : 1;

    bcd_digit_serial_ctrl_if #(.NDIG(NDIG)) bus ();
    bcd_digit_serial_ctrl #(.NDIG(NDIG), .ADD_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    assign bus.in_valid  = in_valid_v[g];
    assign bus.out_ready = out_ready_v[g];
    assign bus.a_bcd     = a_v[g];
    assign bus.b_bcd     = b_v[g];
    assign in_ready_v[g]  = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign dp_issue_v[g]  = bus.dp_issue;
    assign dp_a_v[g]      = bus.dp_a;
    assign dp_b_v[g]      = bus.dp_b;
    assign dp_cin_v[g]    = bus.dp_cin;
    assign zone_v[g]      = bus.zone_phase;
    assign sum_v[g]       = bus.sum_bcd;
    assign cout_v[g]      = bus.cout;
    assign err_v[g]       = bus.err;

    // Slice model: BCD(a+b+cin) valid only in the cycle LAT after the issue cycle
    int         due = -100;
    int         d_now;
    logic [4:0] pend = '0;
    logic [4:0] s_now;
    logic [3:0] s_sum = '0;
    logic       s_tens = 1'b0;
    assign s_now = dp_issue_v[g] ? (5'(dp_a_v[g]) + 5'(dp_b_v[g]) + 5'(dp_cin_v[g])) : pend;
    assign d_now = dp_issue_v[g] ? (cyc + LAT) : due;
    always @(posedge clk) begin
      due  <= d_now;
      pend <= s_now;
      if (cyc + 1 == d_now) begin
        s_sum  <= (s_now > 5'd9) ? 4'(s_now - 5'd10) : 4'(s_now);
        s_tens <= (s_now > 5'd9);
      end else begin
        s_sum  <= 4'bxxxx;
        s_tens <= 1'bx;
      end
    end
    assign bus.dp_sum  = s_sum;
    assign bus.dp_tens = s_tens;

    // Reference: transaction-level view in decimal integers
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_a = 0;
    int          m_b = 0;
    int          m_start = 0;
    int          m_end = 0;
    logic [15:0] m_sum = '0;
    logic        m_cout = 1'b0;
    logic        m_err = 1'b0;
    always @(posedge clk) begin
      if (rst) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
        m_sum  <= '0;
        m_cout <= 1'b0;
        m_err  <= 1'b0;
      end else if (m_done) begin
        if (out_ready_v[g]) m_done <= 1'b0;
      end else if (m_busy) begin
        if (cyc == m_end) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (in_valid_v[g]) begin
        m_a     <= bcd2int(a_v[g]);
        m_b     <= bcd2int(b_v[g]);
        m_start <= cyc;
        if (has_bad(a_v[g]) || has_bad(b_v[g])) begin
          m_done <= 1'b1;
          m_sum  <= '0;
          m_cout <= 1'b0;
          m_err  <= 1'b1;
        end else begin
          m_busy <= 1'b1;
          m_end  <= cyc + NDIG * (LAT + 1);
          m_sum  <= int2bcd((bcd2int(a_v[g]) + bcd2int(b_v[g])) % pow10(NDIG));
          m_cout <= (bcd2int(a_v[g]) + bcd2int(b_v[g])) >= pow10(NDIG);
          m_err  <= 1'b0;
        end
      end
    end

    int          rel, k, off, lo, part;
    logic [1:0]  e_zone;
    logic [15:0] e_sum;
    assign rel    = cyc - m_start - 1;
    assign k      = rel / (LAT + 1);
    assign off    = rel % (LAT + 1);
    assign lo     = pow10(k);
    assign part   = (m_a % lo) + (m_b % lo);
    assign e_zone = !m_busy ? 2'b00 : (off == 0) ? 2'b01 : (off == LAT) ? 2'b11 : 2'b10;
    assign e_sum  = m_busy ? int2bcd(part % lo) : m_sum;

    always @(negedge clk) begin
      if (cyc >= 2) begin
        chk("in_ready", g, in_ready_v[g], !m_busy && !m_done);
        chk("out_valid", g, out_valid_v[g], m_done);
        chk("zone_phase", g, zone_v[g], e_zone);
        chk("dp_issue", g, dp_issue_v[g], m_busy && off == 0);
        chk("sum_bcd", g, sum_v[g], e_sum);
        chk("cout", g, cout_v[g], m_busy ? 1'b0 : m_cout);
        chk("err", g, err_v[g], m_busy ? 1'b0 : m_err);
        if (m_busy) begin
          chk("dp_a", g, dp_a_v[g], (m_a / lo) % 10);
          chk("dp_b", g, dp_b_v[g], (m_b / lo) % 10);
          chk("dp_cin", g, dp_cin_v[g], part >= lo);
        end
      end
    end
  end

  // Wait for out_valid, counting cycles from the accept cycle and recording issued carries
  task automatic wait_done(input int g, output int lat, output int nissue, output logic [3:0] cins);
    lat = 0;
    nissue = 0;
    cins = '0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) in_valid_v[g] = 1'b0;
      if (dp_issue_v[g]) begin
        if (nissue < 4) cins[nissue] = dp_cin_v[g];
        nissue++;
      end
      if (out_valid_v[g]) begin
        lat = n;
        break;
      end
    end
    chk("result_timeout", g, lat != 0, 1);
  endtask

  task automatic run_op(input int g, input logic [15:0] a, input logic [15:0] b, input logic rdy,
                        output int lat, output int nissue, output logic [3:0] cins);
    @(negedge clk);
    a_v[g] = a;
    b_v[g] = b;
    in_valid_v[g] = 1'b1;
    out_ready_v[g] = rdy;
    wait_done(g, lat, nissue, cins);
  endtask

  initial begin
    int         lat;
    int         ni;
    logic [3:0] cins;
    for (int i = 0; i < 2; i++) begin
      in_valid_v[i] = 1'b0;
      out_ready_v[i] = 1'b0;
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 0, in_ready_v[0], 1);
    chk("rst_out_valid", 0, out_valid_v[0], 0);
    chk("rst_zone", 0, zone_v[0], 0);
    chk("rst_dp_a", 0, dp_a_v[0], 0);
    chk("rst_sum", 0, sum_v[0], 0);

    run_op(0, 16'h1234, 16'h5678, 1'b1, lat, ni, cins);
    chk("t1_latency", 0, lat, 21);
    chk("t1_sum", 0, sum_v[0], 16'h6912);
    chk("t1_cout", 0, cout_v[0], 0);
    chk("t1_err", 0, err_v[0], 0);
    @(negedge clk);
    chk("t1_out_valid_drop", 0, out_valid_v[0], 0);
    chk("t1_in_ready_back", 0, in_ready_v[0], 1);

    run_op(0, 16'h9999, 16'h0001, 1'b1, lat, ni, cins);
    chk("t2_issues", 0, ni, 4);
    chk("t2_cin_seq", 0, cins, 4'b1110);
    chk("t2_sum", 0, sum_v[0], 16'h0000);
    chk("t2_cout", 0, cout_v[0], 1);

    run_op(0, 16'h12A4, 16'h0000, 1'b1, lat, ni, cins);
    chk("t3_issues", 0, ni, 0);
    chk("t3_latency", 0, lat, 1);
    chk("t3_err", 0, err_v[0], 1);
    chk("t3_sum", 0, sum_v[0], 0);
    chk("t3_cout", 0, cout_v[0], 0);

    run_op(0, 16'h0042, 16'h0058, 1'b0, lat, ni, cins);
    a_v[0] = 16'h0001;
    b_v[0] = 16'h0002;
    in_valid_v[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("t4_hold_sum", 0, sum_v[0], 16'h0100);
      chk("t4_hold_cout", 0, cout_v[0], 0);
      chk("t4_hold_in_ready", 0, in_ready_v[0], 0);
      chk("t4_hold_out_valid", 0, out_valid_v[0], 1);
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    chk("t4_idle_in_ready", 0, in_ready_v[0], 1);
    chk("t4_no_accept_in_hs", 0, dp_issue_v[0], 0);
    @(negedge clk);
    chk("t4_new_issue", 0, dp_issue_v[0], 1);
    chk("t4_new_dp_a", 0, dp_a_v[0], 1);
    chk("t4_new_dp_b", 0, dp_b_v[0], 2);
    wait_done(0, lat, ni, cins);
    chk("t4_new_sum", 0, sum_v[0], 16'h0003);

    @(negedge clk);
    a_v[0] = 16'h1234;
    b_v[0] = 16'h5678;
    in_valid_v[0] = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 1) in_valid_v[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready", 0, in_ready_v[0], 1);
    chk("t5_out_valid", 0, out_valid_v[0], 0);
    chk("t5_dp_issue", 0, dp_issue_v[0], 0);
    chk("t5_zone", 0, zone_v[0], 0);
    chk("t5_sum", 0, sum_v[0], 0);
    run_op(0, 16'h0005, 16'h0005, 1'b1, lat, ni, cins);
    chk("t5_after_sum", 0, sum_v[0], 16'h0010);
    chk("t5_after_cout", 0, cout_v[0], 0);
    chk("t5_after_latency", 0, lat, 21);

    run_op(1, 16'h0909, 16'h0101, 1'b1, lat, ni, cins);
    chk("t6_latency", 1, lat, 9);
    chk("t6_sum", 1, sum_v[1], 16'h1010);
    chk("t6_cout", 1, cout_v[1], 0);
    chk("t6_cin_seq", 1, cins, 4'b1010);
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
